// File: rtl/dbus_lsu.sv
// dbus_lsu: memory-stage load/store unit talking to a data cache over a
// valid/addr_ok/data_ok bus. One op in flight; minimum occupancy three cycles
// (IDLE accept, REQ, DONE).
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready, in_store, in_size (MSIZE1/2/4/8), in_unsigned,
//   in_addr, in_wdata (right-aligned store data)
//   dreq_valid/addr/size/strobe/data        request to the data cache
//   dresp_addr_ok/data_ok/data              response from the data cache
//   out_valid/out_ready, out_data (extended load data, 0 for stores),
//   out_misalign
//
// Configuration macro: MISALIGN_CHECK_EN. When defined, a misaligned access
// skips the bus entirely and completes with out_misalign = 1, out_data = 0.
// When undefined, every op goes to the bus and out_misalign stays 0.
module dbus_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_store,
  input  logic [2:0]  in_size,
  input  logic        in_unsigned,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_misalign
);

  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic        store_q, store_d;
  logic        unsigned_q, unsigned_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] data_q, data_d;
  logic        misalign_q, misalign_d;

  logic        misalign_fire;
  logic [5:0]  shamt;
  logic [7:0]  strobe_base;
  logic [63:0] load_shifted;
  logic [63:0] load_ext;
  logic [63:0] capture;
  logic        sext;

`ifdef MISALIGN_CHECK_EN
  always_comb begin
    misalign_fire = 1'b0;
    case (in_size)
      MSIZE1:  misalign_fire = 1'b0;
      MSIZE2:  misalign_fire = in_addr[0];
      MSIZE4:  misalign_fire = |in_addr[1:0];
      default: misalign_fire = |in_addr[2:0];
    endcase
  end
`else
  assign misalign_fire = 1'b0;
`endif

  // Byte offset as a bit shift; at most 56, so the shift never reaches 64.
  assign shamt = {addr_q[2:0], 3'b000};

  always_comb begin
    strobe_base = 8'hFF;
    case (size_q)
      MSIZE1:  strobe_base = 8'h01;
      MSIZE2:  strobe_base = 8'h03;
      MSIZE4:  strobe_base = 8'h0F;
      default: strobe_base = 8'hFF;
    endcase
  end

  // Upper bits always come from the extension, never from the raw cache word.
  always_comb begin
    load_shifted = dresp_data >> shamt;
    sext         = ~unsigned_q;
    case (size_q)
      MSIZE1:  load_ext = {{56{sext & load_shifted[7]}}, load_shifted[7:0]};
      MSIZE2:  load_ext = {{48{sext & load_shifted[15]}}, load_shifted[15:0]};
      MSIZE4:  load_ext = {{32{sext & load_shifted[31]}}, load_shifted[31:0]};
      default: load_ext = load_shifted;
    endcase
  end

  assign capture = store_q ? 64'd0 : load_ext;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    store_d    = store_q;
    unsigned_d = unsigned_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    misalign_d = misalign_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          addr_d     = in_addr;
          size_d     = in_size;
          store_d    = in_store;
          unsigned_d = in_unsigned;
          wdata_d    = in_wdata;
          data_d     = 64'd0;
          misalign_d = misalign_fire;
          state_d    = misalign_fire ? StDone : StReq;
        end
      end
      StReq: begin
        if (dresp_addr_ok) begin
          if (dresp_data_ok) begin
            data_d  = capture;
            state_d = StDone;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (dresp_data_ok) begin
          data_d  = capture;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      size_q     <= '0;
      store_q    <= 1'b0;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      data_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      size_q     <= size_d;
      store_q    <= store_d;
      unsigned_q <= unsigned_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      misalign_q <= misalign_d;
    end
  end

  // Reset clears every latched field, so the request bus reads all-zero then.
  assign in_ready     = (state_q == StIdle) && reset;
  assign dreq_valid   = (state_q == StReq);
  assign dreq_addr    = addr_q;
  assign dreq_size    = size_q;
  assign dreq_strobe  = store_q ? (strobe_base << addr_q[2:0]) : 8'd0;
  assign dreq_data    = store_q ? (wdata_q << shamt) : 64'd0;
  assign out_valid    = (state_q == StDone);
  assign out_data     = out_valid ? data_q : 64'd0;
  // Without MISALIGN_CHECK_EN misalign_q can never be set, so this is constant 0.
  assign out_misalign = misalign_q;

endmodule

// File: tb/tb_dbus_lsu.sv
module tb_dbus_lsu;

  localparam logic [2:0] SZ1 = 3'd0;
  localparam logic [2:0] SZ2 = 3'd1;
  localparam logic [2:0] SZ4 = 3'd2;
  localparam logic [2:0] SZ8 = 3'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_store;
  logic [2:0]  in_size;
  logic        in_unsigned;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_misalign;

  always #5 clk = ~clk;

  dbus_lsu dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_store      (in_store),
    .in_size       (in_size),
    .in_unsigned   (in_unsigned),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_misalign  (out_misalign)
  );

  // Per-cycle expectations, written by the driver, read by the compare process.
  logic        e_rst;
  logic        e_in_ready, e_dreq_valid, e_out_valid;
  logic [63:0] e_addr, e_dreq_data, e_out_data;
  logic [2:0]  e_size;
  logic [7:0]  e_strobe;
  logic        e_mis;
  // Hand-computed literal pins for selected vectors.
  logic        lit_en, lit_req_en;
  logic [63:0] lit_out, lit_dreq_data;
  logic [7:0]  lit_strobe;

  int total = 0;
  int bad   = 0;

  // Reference model: byte-level view of the access rules.
  function automatic logic [7:0] m_strobe(input logic [2:0] sz, input logic [63:0] addr);
    int n = 1 << sz;
    int off = int'(addr[2:0]);
    logic [7:0] s = '0;
    for (int i = 0; i < 8; i++) if (i >= off && i < off + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] w, input logic [63:0] addr);
    int off = int'(addr[2:0]);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++) if (i >= off) r[8*i +: 8] = w[8*(i-off) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] word, input logic [2:0] sz,
                                          input logic uns, input logic [63:0] addr);
    int n = 1 << sz;
    int off = int'(addr[2:0]);
    logic [63:0] r = '0;
    logic neg;
    for (int k = 0; k < n; k++) if (off + k < 8) r[8*k +: 8] = word[8*(off+k) +: 8];
    neg = !uns && r[8*n-1];
    for (int k = n; k < 8; k++) if (neg) r[8*k +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic m_mis(input logic [2:0] sz, input logic [63:0] addr);
`ifdef MISALIGN_CHECK_EN
    int n = 1 << sz;
    return (int'(addr[2:0]) % n) != 0;
`else
    return (sz == 3'd7) && (addr == 64'd1);  // never true for legal sizes
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (e_rst) begin
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
      chk("rst_dreq_addr", dreq_addr, 64'd0);
      chk("rst_dreq_data", dreq_data, 64'd0);
      chk("rst_dreq_strobe", {56'd0, dreq_strobe}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_data", out_data, 64'd0);
    end else begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, e_in_ready});
      chk("dreq_valid", {63'd0, dreq_valid}, {63'd0, e_dreq_valid});
      chk("out_valid", {63'd0, out_valid}, {63'd0, e_out_valid});
      if (e_dreq_valid) begin
        chk("dreq_addr", dreq_addr, e_addr);
        chk("dreq_size", {61'd0, dreq_size}, {61'd0, e_size});
        chk("dreq_strobe", {56'd0, dreq_strobe}, {56'd0, e_strobe});
        chk("dreq_data", dreq_data, e_dreq_data);
        if (lit_req_en) begin
          chk("lit_strobe", {56'd0, dreq_strobe}, {56'd0, lit_strobe});
          chk("lit_dreq_data", dreq_data, lit_dreq_data);
        end
      end
      if (e_out_valid) begin
        chk("out_data", out_data, e_out_data);
        chk("out_misalign", {63'd0, out_misalign}, {63'd0, e_mis});
        if (lit_en) chk("lit_out_data", out_data, lit_out);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive the accept cycle and load the model expectations for this op.
  task automatic setup_op(input logic st, input logic [2:0] sz, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] word);
    in_valid      = 1'b1;
    in_store      = st;
    in_size       = sz;
    in_unsigned   = uns;
    in_addr       = addr;
    in_wdata      = wdata;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b1;  // stray data_ok while idle must be ignored
    dresp_data    = ~word;
    e_in_ready    = 1'b1;
    e_dreq_valid  = 1'b0;
    e_out_valid   = 1'b0;
    e_addr        = addr;
    e_size        = sz;
    e_strobe      = st ? m_strobe(sz, addr) : 8'd0;
    e_dreq_data   = st ? m_wdata(wdata, addr) : 64'd0;
    e_mis         = m_mis(sz, addr);
    e_out_data    = (st || e_mis) ? 64'd0 : m_load(word, sz, uns, addr);
  endtask

  // lat = 0: data_ok with addr_ok; lat > 0: data_ok on the lat-th WAIT cycle.
  task automatic run_op(input logic st, input logic [2:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] word, input int lat, input int rdly,
                        input logic le, input logic [63:0] lo);
    lit_en  = le;
    lit_out = lo;
    setup_op(st, sz, uns, addr, wdata, word);
    step();
    // Scramble the inputs to prove the op was latched.
    in_valid     = 1'b0;
    in_addr      = 64'hFFFF_0000_FFFF_0001;
    in_wdata     = 64'h0BAD_0BAD_0BAD_0BAD;
    in_size      = 3'd0;
    in_store     = ~st;
    e_in_ready   = 1'b0;
    if (!e_mis) begin
      e_dreq_valid  = 1'b1;
      dresp_addr_ok = 1'b1;
      dresp_data_ok = (lat == 0);
      dresp_data    = (lat == 0) ? word : ~word;
      step();
      e_dreq_valid  = 1'b0;
      dresp_addr_ok = 1'b0;
      for (int i = 1; i <= lat; i++) begin
        dresp_data_ok = (i == lat);
        dresp_data    = (i == lat) ? word : ~word;
        step();
      end
    end
    e_out_valid   = 1'b1;
    dresp_data_ok = 1'b1;  // late data_ok in DONE must not disturb the result
    dresp_data    = ~word;
    for (int i = 0; i <= rdly; i++) begin
      out_ready = (i == rdly);
      step();
    end
    out_ready     = 1'b0;
    dresp_data_ok = 1'b0;
    e_out_valid   = 1'b0;
    e_in_ready    = 1'b1;
    lit_en        = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_store = 1'b0; in_size = '0; in_unsigned = 1'b0;
    in_addr = '0; in_wdata = '0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0; out_ready = 1'b0;
    e_rst = 1'b1; e_in_ready = 1'b0; e_dreq_valid = 1'b0; e_out_valid = 1'b0;
    e_addr = '0; e_dreq_data = '0; e_out_data = '0; e_size = '0; e_strobe = '0; e_mis = 1'b0;
    lit_en = 1'b0; lit_req_en = 1'b0; lit_out = '0; lit_dreq_data = '0; lit_strobe = '0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; e_rst = 1'b0; e_in_ready = 1'b1;
    step();

    // Load D, single-cycle response.
    run_op(1'b0, SZ8, 1'b0, 64'h8000_0008, 64'd0, 64'h1122_3344_5566_7788, 0, 0,
           1'b1, 64'h1122_3344_5566_7788);
    // Load B signed / unsigned.
    run_op(1'b0, SZ1, 1'b0, 64'h8000_0003, 64'd0, 64'h0000_0000_80FF_0000, 0, 0,
           1'b1, 64'hFFFF_FFFF_FFFF_FF80);
    run_op(1'b0, SZ1, 1'b1, 64'h8000_0003, 64'd0, 64'h0000_0000_80FF_0000, 0, 0,
           1'b1, 64'h0000_0000_0000_0080);
    // Store H.
    lit_req_en = 1'b1; lit_strobe = 8'hC0; lit_dreq_data = 64'hBEEF_0000_0000_0000;
    run_op(1'b1, SZ2, 1'b0, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 64'h1234, 0, 0,
           1'b1, 64'd0);
    lit_req_en = 1'b0;
    // Long WAIT, consumer stalls three cycles.
    run_op(1'b0, SZ4, 1'b0, 64'h8000_0004, 64'd0, 64'hCAFE_BABE_1234_5678, 16, 3,
           1'b1, 64'hFFFF_FFFF_CAFE_BABE);
    // Assorted stores and loads.
    lit_req_en = 1'b1; lit_strobe = 8'hF0; lit_dreq_data = 64'hDEAD_BEEF_0000_0000;
    run_op(1'b1, SZ4, 1'b0, 64'h8000_0004, 64'hFFFF_FFFF_DEAD_BEEF, 64'd0, 2, 1,
           1'b1, 64'd0);
    lit_req_en = 1'b0;
    run_op(1'b1, SZ8, 1'b0, 64'h8000_0010, 64'h0102_0304_0506_0708, 64'd0, 0, 0,
           1'b0, 64'd0);
    run_op(1'b1, SZ1, 1'b0, 64'h8000_0007, 64'h0000_0000_0000_00A5, 64'd0, 1, 0,
           1'b0, 64'd0);
    run_op(1'b0, SZ2, 1'b1, 64'h8000_0002, 64'd0, 64'h0000_0000_9ABC_0000, 3, 0,
           1'b1, 64'h0000_0000_0000_9ABC);
    run_op(1'b0, SZ2, 1'b0, 64'h8000_0002, 64'd0, 64'h0000_0000_9ABC_0000, 0, 2,
           1'b1, 64'hFFFF_FFFF_FFFF_9ABC);
    run_op(1'b0, SZ4, 1'b1, 64'h8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0001, 0, 0,
           1'b1, 64'h0000_0000_8000_0001);
    // Misaligned load W: bus op by default, short-circuited with the check enabled.
`ifdef MISALIGN_CHECK_EN
    run_op(1'b0, SZ4, 1'b0, 64'h8000_0002, 64'd0, 64'h8877_6655_4433_2211, 0, 0,
           1'b1, 64'd0);
`else
    run_op(1'b0, SZ4, 1'b0, 64'h8000_0002, 64'd0, 64'h8877_6655_4433_2211, 0, 0,
           1'b1, 64'h0000_0000_6655_4433);
`endif

    // Reset while in WAIT; a late data_ok after release must be ignored.
    setup_op(1'b0, SZ8, 1'b0, 64'h8000_0010, 64'd0, 64'h0);
    step();
    in_valid = 1'b0; e_in_ready = 1'b0; e_dreq_valid = 1'b1;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b0;
    step();
    e_dreq_valid = 1'b0; dresp_addr_ok = 1'b0;
    step();
    reset = 1'b0; e_rst = 1'b1;
    step();
    step();
    reset = 1'b1; e_rst = 1'b0; e_in_ready = 1'b1;
    dresp_data_ok = 1'b1; dresp_data = 64'h5555_AAAA_5555_AAAA;
    step();
    step();
    dresp_data_ok = 1'b0;
    run_op(1'b0, SZ8, 1'b0, 64'h8000_0018, 64'd0, 64'h0F0E_0D0C_0B0A_0908, 1, 0,
           1'b1, 64'h0F0E_0D0C_0B0A_0908);

    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbus_lsu.md
DBUS_LSU -- requirements
Module: dbus_lsu

Interface
REQ-001 Parameters: none; widths are fixed by common package types (word_t = 64, addr 64, strobe_t = 8, msize_t).
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  memory-stage op present.
REQ-005 in_ready  output  1  op accepted on in_valid && in_ready.
REQ-006 in_store  input  1  1 = store, 0 = load.
REQ-007 in_size  input  msize_t  MSIZE1/2/4/8.
REQ-008 in_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 in_addr  input  64  byte address.
REQ-010 in_wdata  input  64  store data, right-aligned.
REQ-011 dreq  output  dbus_req_t  request to the data cache.
REQ-012 dresp  input  dbus_resp_t  response from the data cache.
REQ-013 out_valid  output  1  result ready; held until out_ready.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 out_data  output  64  extended load data; 0 for stores.
REQ-016 out_misalign  output  1  misaligned-access flag; meaningful only under MISALIGN_CHECK_EN.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, DONE; in_ready = (state == IDLE).
REQ-018 IDLE: on accept, latch the op and go to REQ, or go to DONE with out_misalign = 1 when the misalign check fires.
REQ-019 REQ: dreq.valid = 1 with latched fields held stable.
REQ-020 REQ, dresp.addr_ok && dresp.data_ok in the same cycle: capture data and go to DONE.
REQ-021 REQ, addr_ok only: go to WAIT, with dreq.valid = 0 from the next cycle.
REQ-022 WAIT: on dresp.data_ok, capture data and go to DONE.
REQ-023 data_ok seen in IDLE or DONE is ignored.
REQ-024 DONE: out_valid = 1; out_data and out_misalign held stable; go to IDLE on out_ready.
REQ-025 No new op is accepted in the DONE exit cycle; minimum occupancy is 3 cycles per op (IDLE, REQ, DONE).
REQ-026 dreq.addr = latched address unmodified; dreq.size = in_size.
REQ-027 Store strobe (before shift): 8'h01 for B, 8'h03 for H, 8'h0F for W, 8'hFF for D.
REQ-028 Store dreq.strobe = that strobe shifted left by addr[2:0]; dreq.data = wdata << (8*addr[2:0]).
REQ-029 Load: dreq.strobe = 0 and dreq.data = 0.
REQ-030 Load result = dresp.data >> (8*addr[2:0]), truncated to size, then sign- or zero-extended to 64.
REQ-031 Result bits wider than the access size are never taken from the raw cache word.
REQ-032 Store completion: out_data = 0.
REQ-033 Shift amounts are 6-bit; any shift >= 64 yields 0.

Reset
REQ-034 reset low asynchronously forces state = IDLE and clears all latched op fields.
REQ-035 reset low also clears captured data, out_misalign and out_valid.
REQ-036 While reset is low: dreq = '0, in_ready = 0, out_valid = 0, out_data = 0.
REQ-037 After reset deasserts: in_ready = 1 from the first clock edge.
REQ-038 Reset mid-transaction (REQ/WAIT) abandons the op with no retry; a late data_ok is ignored per REQ-023.

Configuration
REQ-039 Macro MISALIGN_CHECK_EN defined: an access with addr not a multiple of its size (H: addr[0], W: addr[1:0], D: addr[2:0] nonzero) issues no dbus request.
REQ-040 Such an access enters DONE on the cycle after accept with out_misalign = 1 and out_data = 0.
REQ-041 Macro undefined: no check; every op issues a dbus request; out_misalign tied 0.

Verification
REQ-042 Load D @0x80000008, cache returns 0x1122334455667788 with addr_ok and data_ok in the same cycle -> out_data 0x1122334455667788, out_valid 2 cycles after accept.
REQ-043 Load B signed @0x80000003, word 0x0000_0000_80FF_0000 -> out_data 0xFFFFFFFFFFFFFF80; the same with in_unsigned=1 -> out_data 0x80.
REQ-044 Store H 0xBEEF @0x80000006 -> dreq.strobe 8'hC0, dreq.data 0xBEEF000000000000, dreq.size MSIZE2; out_data 0.
REQ-045 addr_ok at cycle 1, data_ok 16 cycles later, out_ready held low for 3 cycles -> dreq.valid high exactly 1 cycle; out_valid/out_data stable for 4 cycles; in_ready low throughout.
REQ-046 reset pulled low while in WAIT, then data_ok arrives after release -> no out_valid; in_ready = 1; next op completes normally.
REQ-047 With MISALIGN_CHECK_EN, load W @0x80000002 -> dreq.valid never asserted; out_valid with out_misalign = 1 on the cycle after accept.
